// File: rtl/ahb_fir_fifo.sv
// Sample buffer behind the AHB FIR filter. Captured samples are drained over a
// zero-wait AHB-Lite slave with DATA/STATUS/CTRL/THRESH registers and a level irq.
module ahb_fir_fifo #(
  parameter int AWIDTH   = 32,
  parameter int DWIDTH   = 32,
  parameter int OUT_SIZE = 32,
  parameter int DEPTH    = 16,
  parameter int CW       = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                hsel,
  input  logic [AWIDTH-1:0]   haddr,
  input  logic [2:0]          hsize,
  input  logic                hwrite,
  input  logic [1:0]          htrans,
  input  logic [DWIDTH-1:0]   hwdata,
  input  logic                hready,
  output logic                hreadyout,
  output logic                hresp,
  output logic [DWIDTH-1:0]   hrdata,
  input  logic [OUT_SIZE-1:0] in_wave,
  input  logic                write_en,
  output logic                irq
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_CTRL   = 2'd2,
    REG_THRESH = 2'd3
  } reg_e;

  logic          hsel_1, hwrite_1;
  logic [1:0]    htrans_1;
  logic [2:0]    hsize_1;
  reg_e          addr_1;

  logic [OUT_SIZE-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, thresh;
  logic          overflow, underflow;

  logic empty, full, valid, rd_valid, wr_valid;
  logic pop, push, flush, ovf_set, udf_set, ovf_clr, udf_clr;
  logic [DWIDTH-1:0] status;

  assign hreadyout = 1'b1;
  assign hresp     = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsel_1   <= 1'b0;
      hwrite_1 <= 1'b0;
      htrans_1 <= '0;
      hsize_1  <= '0;
      addr_1   <= REG_DATA;
    end else if (hready) begin
      hsel_1   <= hsel;
      hwrite_1 <= hwrite;
      htrans_1 <= htrans;
      hsize_1  <= hsize;
      addr_1   <= reg_e'(haddr[3:2]);
    end
  end

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign valid    = hsel_1 & htrans_1[1];
  assign rd_valid = valid & ~hwrite_1;
  assign wr_valid = valid & hwrite_1;

  assign flush   = wr_valid & (addr_1 == REG_CTRL) & hwdata[0];
  assign ovf_clr = wr_valid & (addr_1 == REG_CTRL) & hwdata[1];
  assign udf_clr = wr_valid & (addr_1 == REG_CTRL) & hwdata[2];

  // A pop frees the slot a full push needs, so both proceed in that cycle.
  assign pop     = rd_valid & (addr_1 == REG_DATA) & ~empty & ~flush;
  assign udf_set = rd_valid & (addr_1 == REG_DATA) & empty;
  assign push    = write_en & (~full | pop) & ~flush;
  assign ovf_set = write_en & full & ~pop & ~flush;

  always_comb begin
    status           = '0;
    status[CW-1:0]   = count;
    status[16]       = empty;
    status[17]       = full;
    status[18]       = overflow;
    status[19]       = underflow;
  end

  always_comb begin
    hrdata = '0;
    if (rd_valid) begin
      unique case (addr_1)
        REG_DATA:   hrdata = empty ? '0 : DWIDTH'($signed(mem[rd_ptr]));
        REG_STATUS: hrdata = status;
        REG_CTRL:   hrdata = '0;
        REG_THRESH: hrdata = DWIDTH'(thresh);
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_wave;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      thresh    <= CW'(1);
      irq       <= 1'b0;
    end else begin
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        count <= count + CW'(push) - CW'(pop);
      end
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
      if (udf_set)      underflow <= 1'b1;
      else if (udf_clr) underflow <= 1'b0;
      if (wr_valid && addr_1 == REG_THRESH) thresh <= hwdata[CW-1:0];
      irq <= ((count >= thresh) && (thresh != '0)) | overflow;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{hsize_1, haddr[AWIDTH-1:4], haddr[1:0], hwdata[DWIDTH-1:CW]};

endmodule

// File: tb/tb_ahb_fir_fifo.sv
// Self-checking bench for ahb_fir_fifo: register vector table plus scoreboarded
// FIFO sequences (overflow, full push+pop across wrap, threshold irq, async reset).
module tb_ahb_fir_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hsel, hwrite, hready, write_en;
  logic [31:0] haddr, hwdata, in_wave;
  logic [2:0]  hsize;
  logic [1:0]  htrans;
  logic        hreadyout, hresp, irq;
  logic [31:0] hrdata;

  ahb_fir_fifo #(.AWIDTH(32), .DWIDTH(32), .OUT_SIZE(32), .DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .hsel(hsel), .haddr(haddr), .hsize(hsize),
    .hwrite(hwrite), .htrans(htrans), .hwdata(hwdata), .hready(hready),
    .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata),
    .in_wave(in_wave), .write_en(write_en), .irq(irq)
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [31:0] sb[$];
  bit          m_ovf, m_udf;
  int unsigned m_thresh;

  typedef struct {
    logic [1:0]  addr;
    bit          wr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s = '0;
    s[4:0] = 5'(sb.size());
    s[16]  = (sb.size() == 0);
    s[17]  = (sb.size() == 16);
    s[18]  = m_ovf;
    s[19]  = m_udf;
    return s;
  endfunction

  function automatic void m_push(logic [31:0] v);
    if (sb.size() < 16) sb.push_back(v);
    else m_ovf = 1'b1;
  endfunction

  task automatic ahb_xfer(input logic [1:0] a, input bit wr, input logic [31:0] wd,
                          input bit pe, input logic [31:0] pv, output logic [31:0] rd);
    hsel = 1'b1; haddr = {28'h0, a, 2'b00}; hwrite = wr; htrans = 2'b10;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = wd;
    write_en = pe; in_wave = pv;
    rd = hrdata;
    @(posedge clk); #1;
    write_en = 1'b0;
  endtask

  task automatic push(input logic [31:0] v);
    write_en = 1'b1; in_wave = v;
    @(posedge clk); #1;
    write_en = 1'b0;
    m_push(v);
  endtask

  task automatic rd_data(input bit pe, input logic [31:0] pv);
    logic [31:0] r, e;
    ahb_xfer(2'd0, 1'b0, '0, pe, pv, r);
    if (sb.size() != 0) e = sb.pop_front();
    else begin e = '0; m_udf = 1'b1; end
    if (pe) m_push(pv);
    check("data", r, e);
  endtask

  task automatic rd_status();
    logic [31:0] r;
    ahb_xfer(2'd1, 1'b0, '0, 1'b0, '0, r);
    check("status", r, exp_status());
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    logic [31:0] r;
    ahb_xfer(a, 1'b1, d, 1'b0, '0, r);
  endtask

  task automatic check_irq();
    @(posedge clk); #1;
    check("irq", {31'b0, irq},
          {31'b0, ((sb.size() >= m_thresh) && (m_thresh != 0)) || m_ovf});
  endtask

  initial begin
    vec_t vt[10];
    logic [31:0] r;
    vt[0] = '{2'd1, 1'b0, 32'h0,         32'h0001_0000};
    vt[1] = '{2'd3, 1'b0, 32'h0,         32'h0000_0001};
    vt[2] = '{2'd2, 1'b0, 32'h0,         32'h0000_0000};
    vt[3] = '{2'd3, 1'b1, 32'hFFFF_FFFF, 32'h0};
    vt[4] = '{2'd3, 1'b0, 32'h0,         32'h0000_001F};
    vt[5] = '{2'd3, 1'b1, 32'h0000_0001, 32'h0};
    vt[6] = '{2'd0, 1'b0, 32'h0,         32'h0000_0000};
    vt[7] = '{2'd1, 1'b0, 32'h0,         32'h0009_0000};
    vt[8] = '{2'd2, 1'b1, 32'h0000_0004, 32'h0};
    vt[9] = '{2'd1, 1'b0, 32'h0,         32'h0001_0000};

    rst_n = 1'b0; hsel = 1'b0; haddr = '0; hsize = 3'b010; hwrite = 1'b0;
    htrans = 2'b00; hwdata = '0; hready = 1'b1; write_en = 1'b0; in_wave = '0;
    m_ovf = 1'b0; m_udf = 1'b0; m_thresh = 1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    check("rst_irq", {31'b0, irq}, 32'h0);
    check("rst_hreadyout", {31'b0, hreadyout}, 32'h1);
    check("rst_hresp", {31'b0, hresp}, 32'h0);
    check("rst_hrdata", hrdata, 32'h0);

    foreach (vt[i]) begin
      ahb_xfer(vt[i].addr, vt[i].wr, vt[i].wdata, 1'b0, '0, r);
      if (!vt[i].wr) check($sformatf("vec%0d", i), r, vt[i].exp);
    end

    // Basic signed samples
    push(32'hFFFF_FFFB); push(32'd7); push(32'd300);
    rd_status();
    repeat (3) rd_data(1'b0, '0);
    rd_status();

    // Overflow on the 17th push
    for (int i = 0; i < 17; i++) push($urandom);
    rd_status();
    check_irq();
    for (int i = 0; i < 16; i++) rd_data(1'b0, '0);
    wr_reg(2'd2, 32'h2); m_ovf = 1'b0;
    rd_status();

    // Full push with concurrent pop, pointers offset to force a wrap
    for (int i = 0; i < 5; i++) push($urandom);
    for (int i = 0; i < 5; i++) rd_data(1'b0, '0);
    for (int i = 0; i < 16; i++) push(32'h100 + i);
    for (int i = 0; i < 3; i++) rd_data(1'b1, 32'h200 + i);
    rd_status();
    check_irq();
    for (int i = 0; i < 16; i++) rd_data(1'b0, '0);
    rd_status();

    // Threshold irq and flush with concurrent push
    wr_reg(2'd3, 32'd4); m_thresh = 4;
    for (int i = 0; i < 3; i++) push(32'h300 + i);
    check_irq();
    push(32'h303);
    check("irq_lag", {31'b0, irq}, 32'h0);
    @(posedge clk); #1;
    check("irq_set", {31'b0, irq}, 32'h1);
    ahb_xfer(2'd2, 1'b1, 32'h1, 1'b1, 32'h400, r);
    sb.delete();
    check_irq();
    rd_status();

    // Asynchronous reset during a DATA transfer with 5 buffered samples
    for (int i = 0; i < 5; i++) push(32'h500 + i);
    check_irq();
    hsel = 1'b1; haddr = 32'h0; hwrite = 1'b0; htrans = 2'b10;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00;
    check("pre_rst_data", hrdata, sb[0]);
    #2 rst_n = 1'b0;
    #1;
    check("arst_hrdata", hrdata, 32'h0);
    check("arst_irq", {31'b0, irq}, 32'h0);
    check("arst_hreadyout", {31'b0, hreadyout}, 32'h1);
    check("arst_hresp", {31'b0, hresp}, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    sb.delete(); m_ovf = 1'b0; m_udf = 1'b0; m_thresh = 1;
    rd_status();
    ahb_xfer(2'd3, 1'b0, '0, 1'b0, '0, r);
    check("post_rst_thresh", r, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
